wb_cdb_arbiter: RTL and testbench

//  Consumer side of the EX/MEM pipeline register: collects up to NUM_IN completed results per cycle
//  (three ALU issue lanes plus the LSQ load-return lane) into an in-order result buffer.

---
 rtl/riscv_ooo_pkg.sv | 18 +
 rtl/wb_result_fifo.sv | 59 +++++
 rtl/wb_cdb_arbiter.sv | 109 ++++++++++
 tb/tb_wb_cdb_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ooo_pkg.sv
// Shared types and widths for the out-of-order RISC-V core back end.
// cdb_entry_t is the payload carried through the writeback buffer and onto the CDB.
package riscv_ooo_pkg;

    localparam int XLEN          = 32;
    localparam int PREG_W        = 6;
    localparam int ROB_W         = 6;
    localparam int NUM_ALU_LANES = 3;
    localparam int LSQ_LANE      = 3;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   data;
        logic [PREG_W-1:0] dest;
        logic [ROB_W-1:0]  rob;
    } cdb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Circular result buffer: up to NUM_IN writes and CDB_WIDTH reads per cycle.
// The caller supplies each lane's compacted offset from the tail, plus the push and pop counts.
module wb_result_fifo
    import riscv_ooo_pkg::*;
#(
    parameter int NUM_IN    = 4,
    parameter int CDB_WIDTH = 2,
    parameter int DEPTH     = 8,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int OCC_W    = $clog2(DEPTH + 1)
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               flush,
    input  logic [NUM_IN-1:0]                  wr_en,
    input  logic [NUM_IN-1:0][PTR_W-1:0]       wr_off,
    input  cdb_entry_t [NUM_IN-1:0]            wr_data,
    input  logic [OCC_W-1:0]                   push_cnt,
    input  logic [OCC_W-1:0]                   pop_cnt,
    output cdb_entry_t [CDB_WIDTH-1:0]         rd_data,
    output logic [OCC_W-1:0]                   occupancy
);

    cdb_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    // Storage is not reset; only entries covered by occupancy are ever consumed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_IN; i++) begin
            if (wr_en[i]) begin
                mem[tail + wr_off[i]] <= wr_data[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
        end else if (flush) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
        end else begin
            head      <= head + PTR_W'(pop_cnt);
            tail      <= tail + PTR_W'(push_cnt);
            occupancy <= occupancy + push_cnt - pop_cnt;
        end
    end

    always_comb begin
        for (int j = 0; j < CDB_WIDTH; j++) begin
            rd_data[j] = mem[head + PTR_W'(j)];
        end
    end

endmodule

// File: rtl/wb_cdb_arbiter.sv
// Writeback arbiter: compacts completed EX/LSQ results into an in-order buffer and
// broadcasts the oldest CDB_WIDTH entries per cycle on registered CDB slots.
module wb_cdb_arbiter
    import riscv_ooo_pkg::*;
#(
    parameter int NUM_IN    = 4,
    parameter int CDB_WIDTH = 2,
    parameter int DEPTH     = 8,
    parameter int PREG_W    = riscv_ooo_pkg::PREG_W,
    parameter int ROB_W     = riscv_ooo_pkg::ROB_W,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int OCC_W    = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          flush,
    input  logic [NUM_IN-1:0]             in_valid,
    input  logic [NUM_IN*32-1:0]          in_pc,
    input  logic [NUM_IN*32-1:0]          in_data,
    input  logic [NUM_IN*PREG_W-1:0]      in_dest,
    input  logic [NUM_IN*ROB_W-1:0]       in_rob,
    output logic                          in_ready,
    output logic [CDB_WIDTH-1:0]          cdb_valid,
    output logic [CDB_WIDTH*32-1:0]       cdb_pc,
    output logic [CDB_WIDTH*32-1:0]       cdb_data,
    output logic [CDB_WIDTH*PREG_W-1:0]   cdb_dest,
    output logic [CDB_WIDTH*ROB_W-1:0]    cdb_rob,
    output logic [CDB_WIDTH-1:0]          cdb_rf_we,
    output logic [OCC_W-1:0]              occupancy,
    output logic                          overflow_err
);

    cdb_entry_t [NUM_IN-1:0]       lane_ent;
    logic [NUM_IN-1:0][PTR_W-1:0]  lane_off;
    cdb_entry_t [CDB_WIDTH-1:0]    head_ent;
    logic [OCC_W-1:0]              run;
    logic [OCC_W-1:0]              push_cnt;
    logic [OCC_W-1:0]              pop_cnt;
    logic                          accept;

    // Backpressure looks only at registered occupancy, never at this cycle's pops.
    assign in_ready = (OCC_W'(DEPTH) - occupancy) >= OCC_W'(NUM_IN);
    assign accept   = in_ready && !flush;
    assign pop_cnt  = (occupancy < OCC_W'(CDB_WIDTH)) ? occupancy : OCC_W'(CDB_WIDTH);

    // Each valid lane lands at tail + (number of valid lanes below it).
    always_comb begin
        run = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            lane_ent[i].pc   = in_pc[32*i +: 32];
            lane_ent[i].data = in_data[32*i +: 32];
            lane_ent[i].dest = in_dest[PREG_W*i +: PREG_W];
            lane_ent[i].rob  = in_rob[ROB_W*i +: ROB_W];
            lane_off[i]      = PTR_W'(run);
            run              = run + OCC_W'(in_valid[i]);
        end
        push_cnt = accept ? run : '0;
    end

    wb_result_fifo #(
        .NUM_IN    (NUM_IN),
        .CDB_WIDTH (CDB_WIDTH),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .wr_en     (in_valid & {NUM_IN{accept}}),
        .wr_off    (lane_off),
        .wr_data   (lane_ent),
        .push_cnt  (push_cnt),
        .pop_cnt   (pop_cnt),
        .rd_data   (head_ent),
        .occupancy (occupancy)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cdb_valid <= '0;
            cdb_rf_we <= '0;
            cdb_pc    <= '0;
            cdb_data  <= '0;
            cdb_dest  <= '0;
            cdb_rob   <= '0;
        end else if (flush) begin
            cdb_valid <= '0;
            cdb_rf_we <= '0;
        end else begin
            for (int j = 0; j < CDB_WIDTH; j++) begin
                cdb_valid[j]                <= OCC_W'(j) < pop_cnt;
                cdb_rf_we[j]                <= (OCC_W'(j) < pop_cnt) && (head_ent[j].dest != '0);
                cdb_pc[32*j +: 32]          <= head_ent[j].pc;
                cdb_data[32*j +: 32]        <= head_ent[j].data;
                cdb_dest[PREG_W*j +: PREG_W] <= head_ent[j].dest;
                cdb_rob[ROB_W*j +: ROB_W]   <= head_ent[j].rob;
            end
        end
    end

    // Sticky until reset; a flush edge drops lanes without counting as an overflow.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow_err <= 1'b0;
        end else if (!flush && !in_ready && (|in_valid)) begin
            overflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_cdb_arbiter.sv
// Self-checking bench for wb_cdb_arbiter: a queue-based model predicts CDB slots,
// occupancy, in_ready and overflow_err for directed and randomized traffic.
module tb_wb_cdb_arbiter;
    import riscv_ooo_pkg::*;

    localparam int NUM_IN    = 4;
    localparam int CDB_WIDTH = 2;
    localparam int DEPTH     = 8;
    localparam int OCC_W     = $clog2(DEPTH + 1);
    localparam int SW        = 2 + $bits(cdb_entry_t);
    localparam int VW        = CDB_WIDTH * SW + OCC_W + 2;

    logic                        clk = 1'b0;
    logic                        rstn = 1'b0;
    logic                        flush;
    logic [NUM_IN-1:0]           in_valid;
    logic [NUM_IN*32-1:0]        in_pc;
    logic [NUM_IN*32-1:0]        in_data;
    logic [NUM_IN*PREG_W-1:0]    in_dest;
    logic [NUM_IN*ROB_W-1:0]     in_rob;
    logic                        in_ready;
    logic [CDB_WIDTH-1:0]        cdb_valid;
    logic [CDB_WIDTH*32-1:0]     cdb_pc;
    logic [CDB_WIDTH*32-1:0]     cdb_data;
    logic [CDB_WIDTH*PREG_W-1:0] cdb_dest;
    logic [CDB_WIDTH*ROB_W-1:0]  cdb_rob;
    logic [CDB_WIDTH-1:0]        cdb_rf_we;
    logic [OCC_W-1:0]            occupancy;
    logic                        overflow_err;

    int n_checks = 0;
    int n_fail   = 0;

    cdb_entry_t           mq[$];
    logic [CDB_WIDTH-1:0] exp_valid;
    cdb_entry_t           exp_ent[CDB_WIDTH];
    logic                 exp_ovf;

    wb_cdb_arbiter #(
        .NUM_IN    (NUM_IN),
        .CDB_WIDTH (CDB_WIDTH),
        .DEPTH     (DEPTH)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_pc        (in_pc),
        .in_data      (in_data),
        .in_dest      (in_dest),
        .in_rob       (in_rob),
        .in_ready     (in_ready),
        .cdb_valid    (cdb_valid),
        .cdb_pc       (cdb_pc),
        .cdb_data     (cdb_data),
        .cdb_dest     (cdb_dest),
        .cdb_rob      (cdb_rob),
        .cdb_rf_we    (cdb_rf_we),
        .occupancy    (occupancy),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] exp_vec();
        logic [VW-1:0] v;
        v = '0;
        for (int j = 0; j < CDB_WIDTH; j++) begin
            v[j*SW +: SW] = exp_valid[j] ? {1'b1, exp_ent[j].dest != '0, exp_ent[j]} : '0;
        end
        v[CDB_WIDTH*SW +: OCC_W+2] = {OCC_W'(mq.size()), (DEPTH - mq.size()) >= NUM_IN, exp_ovf};
        return v;
    endfunction

    // Payload of slots the model says are idle is don't-care, so it is masked out.
    function automatic logic [VW-1:0] act_vec();
        logic [VW-1:0] v;
        cdb_entry_t    e;
        v = '0;
        for (int j = 0; j < CDB_WIDTH; j++) begin
            e.pc   = cdb_pc[32*j +: 32];
            e.data = cdb_data[32*j +: 32];
            e.dest = cdb_dest[PREG_W*j +: PREG_W];
            e.rob  = cdb_rob[ROB_W*j +: ROB_W];
            if (!exp_valid[j]) e = '0;
            v[j*SW +: SW] = {cdb_valid[j], cdb_rf_we[j], e};
        end
        v[CDB_WIDTH*SW +: OCC_W+2] = {occupancy, in_ready, overflow_err};
        return v;
    endfunction

    task automatic idle();
        in_valid = '0;
        flush    = 1'b0;
    endtask

    task automatic set_lane(input int i, input logic [31:0] pc, input logic [31:0] data,
                            input logic [PREG_W-1:0] dest, input logic [ROB_W-1:0] rob);
        in_valid[i]                 = 1'b1;
        in_pc[32*i +: 32]           = pc;
        in_data[32*i +: 32]         = data;
        in_dest[PREG_W*i +: PREG_W] = dest;
        in_rob[ROB_W*i +: ROB_W]    = rob;
    endtask

    task automatic rand_lane(input int i);
        set_lane(i, $urandom, $urandom, PREG_W'($urandom), ROB_W'($urandom));
    endtask

    task automatic model_reset();
        mq.delete();
        exp_valid = '0;
        exp_ovf   = 1'b0;
        for (int j = 0; j < CDB_WIDTH; j++) exp_ent[j] = '0;
    endtask

    // Predicts the edge from the pre-edge queue, then advances and parks 1 ns after it.
    task automatic clock_edge();
        int         pops;
        bit         ready;
        cdb_entry_t e;
        ready = (DEPTH - mq.size()) >= NUM_IN;
        pops  = (mq.size() < CDB_WIDTH) ? mq.size() : CDB_WIDTH;
        if (flush) begin
            mq.delete();
            exp_valid = '0;
        end else begin
            for (int j = 0; j < CDB_WIDTH; j++) begin
                exp_valid[j] = (j < pops);
                if (j < pops) exp_ent[j] = mq.pop_front();
            end
            if (ready) begin
                for (int i = 0; i < NUM_IN; i++) begin
                    if (in_valid[i]) begin
                        e.pc   = in_pc[32*i +: 32];
                        e.data = in_data[32*i +: 32];
                        e.dest = in_dest[PREG_W*i +: PREG_W];
                        e.rob  = in_rob[ROB_W*i +: ROB_W];
                        mq.push_back(e);
                    end
                end
            end else if (|in_valid) begin
                exp_ovf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        for (int k = 0; k < 2 * DEPTH && mq.size() > 0; k++) clock_edge();
        clock_edge();
    endtask

    task automatic test_reset();
        idle();
        in_pc = '0; in_data = '0; in_dest = '0; in_rob = '0;
        model_reset();
        rstn = 1'b0;
        #3;
        n_checks++;
        if ({cdb_valid, cdb_rf_we, cdb_pc, cdb_data, cdb_dest, cdb_rob, occupancy, overflow_err, in_ready}
            !== {{(VW-1){1'b0}}, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL reset_state: got valid=%b occ=%0d ovf=%b ready=%b, expected all zero with ready=1",
                     cdb_valid, occupancy, overflow_err, in_ready);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_single_lane();
        idle();
        set_lane(1, 32'h100, 32'hDEAD, 6'd5, 6'd3);
        clock_edge();
        n_checks++;
        if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("[TB] FAIL single_accept: got %h expected %h", act_vec(), exp_vec());
        end
        idle();
        clock_edge();
        n_checks++;
        if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("[TB] FAIL single_bcast: got %h expected %h", act_vec(), exp_vec());
        end
        n_checks++;
        if ({cdb_valid, cdb_rf_we, cdb_pc[31:0], cdb_data[31:0], cdb_dest[5:0], cdb_rob[5:0]}
            !== {2'b01, 2'b01, 32'h100, 32'hDEAD, 6'd5, 6'd3}) begin
            n_fail++;
            $display("[TB] FAIL single_slot0: got valid=%b we=%b pc=%h data=%h dest=%0d rob=%0d, expected 01 01 100 dead 5 3",
                     cdb_valid, cdb_rf_we, cdb_pc[31:0], cdb_data[31:0], cdb_dest[5:0], cdb_rob[5:0]);
        end
        drain();
    endtask

    task automatic test_all_lanes();
        idle();
        for (int i = 0; i < NUM_IN; i++) set_lane(i, $urandom, $urandom, PREG_W'(i + 1), ROB_W'(10 + i));
        clock_edge();
        idle();
        for (int c = 0; c < 2; c++) begin
            clock_edge();
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL all_lanes cycle %0d: got %h expected %h", c, act_vec(), exp_vec());
            end
            n_checks++;
            if ({occupancy, cdb_rob[5:0], cdb_rob[11:6]} !== {OCC_W'(2 - 2 * c), 6'(10 + 2 * c), 6'(11 + 2 * c)}) begin
                n_fail++;
                $display("[TB] FAIL all_lanes_order cycle %0d: got occ=%0d rob=%0d,%0d expected occ=%0d rob=%0d,%0d",
                         c, occupancy, cdb_rob[5:0], cdb_rob[11:6], 2 - 2 * c, 10 + 2 * c, 11 + 2 * c);
            end
        end
        drain();
    endtask

    task automatic test_compaction();
        for (int r = 0; r < 3; r++) begin
            idle();
            rand_lane(0); in_rob[5:0] = 6'd20;
            rand_lane(2); in_rob[17:12] = 6'd22;
            clock_edge();
            idle();
            rand_lane(1); in_rob[11:6] = 6'd31;
            rand_lane(3); in_rob[23:18] = 6'd33;
            clock_edge();
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL compaction round %0d: got %h expected %h", r, act_vec(), exp_vec());
            end
            if (r == 0) begin
                n_checks++;
                if ({cdb_valid, cdb_rob[5:0], cdb_rob[11:6]} !== {2'b11, 6'd20, 6'd22}) begin
                    n_fail++;
                    $display("[TB] FAIL compaction_order: got valid=%b rob=%0d,%0d expected 11 rob=20,22",
                             cdb_valid, cdb_rob[5:0], cdb_rob[11:6]);
                end
            end
        end
        idle();
        for (int c = 0; c < 4; c++) begin
            clock_edge();
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL compaction_drain cycle %0d: got %h expected %h", c, act_vec(), exp_vec());
            end
        end
        drain();
    endtask

    task automatic test_overflow();
        for (int c = 0; c < 2; c++) begin
            idle();
            for (int i = 0; i < NUM_IN; i++) rand_lane(i);
            clock_edge();
        end
        n_checks++;
        if ({occupancy, in_ready} !== {OCC_W'(6), 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL overflow_fill: got occ=%0d ready=%b expected occ=6 ready=0", occupancy, in_ready);
        end
        idle();
        rand_lane(0);
        clock_edge();
        n_checks++;
        if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("[TB] FAIL overflow_drop: got %h expected %h", act_vec(), exp_vec());
        end
        n_checks++;
        if ({occupancy, overflow_err} !== {OCC_W'(4), 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL overflow_flag: got occ=%0d ovf=%b expected occ=4 ovf=1", occupancy, overflow_err);
        end
        drain();
    endtask

    task automatic test_flush();
        idle();
        for (int i = 0; i < 3; i++) rand_lane(i);
        clock_edge();
        idle();
        for (int i = 0; i < NUM_IN; i++) rand_lane(i);
        clock_edge();
        n_checks++;
        if (occupancy !== OCC_W'(5)) begin
            n_fail++;
            $display("[TB] FAIL flush_setup: got occ=%0d expected 5", occupancy);
        end
        for (int i = 0; i < NUM_IN; i++) rand_lane(i);
        flush = 1'b1;
        clock_edge();
        idle();
        n_checks++;
        if ({occupancy, cdb_valid, cdb_rf_we, in_ready} !== {OCC_W'(0), 2'b00, 2'b00, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL flush_clear: got occ=%0d valid=%b we=%b ready=%b expected 0 00 00 1",
                     occupancy, cdb_valid, cdb_rf_we, in_ready);
        end
        n_checks++;
        if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("[TB] FAIL flush_model: got %h expected %h", act_vec(), exp_vec());
        end
        drain();
    endtask

    task automatic test_dest_zero_and_reset();
        idle();
        set_lane(2, 32'h200, 32'hBEEF, 6'd0, 6'd40);
        clock_edge();
        idle();
        clock_edge();
        n_checks++;
        if ({cdb_valid[0], cdb_rf_we[0], cdb_rob[5:0]} !== {1'b1, 1'b0, 6'd40}) begin
            n_fail++;
            $display("[TB] FAIL dest_zero: got valid=%b we=%b rob=%0d expected 1 0 40",
                     cdb_valid[0], cdb_rf_we[0], cdb_rob[5:0]);
        end
        for (int i = 0; i < NUM_IN; i++) set_lane(i, $urandom, $urandom, PREG_W'(i + 1), ROB_W'(50 + i));
        clock_edge();
        idle();
        clock_edge();
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({cdb_valid, cdb_rf_we, cdb_pc, cdb_data, cdb_dest, cdb_rob, occupancy, overflow_err, in_ready}
            !== {{(VW-1){1'b0}}, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL async_reset: got valid=%b we=%b occ=%0d ovf=%b ready=%b expected all zero with ready=1",
                     cdb_valid, cdb_rf_we, occupancy, overflow_err, in_ready);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            idle();
            if (((DEPTH - mq.size()) >= NUM_IN) || ($urandom_range(0, 3) == 0)) begin
                for (int i = 0; i < NUM_IN; i++) if ($urandom_range(0, 1) == 1) rand_lane(i);
            end
            flush = ($urandom_range(0, 19) == 0);
            clock_edge();
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL random cycle %0d: got %h expected %h", c, act_vec(), exp_vec());
            end
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single_lane();
        test_all_lanes();
        test_compaction();
        test_overflow();
        test_flush();
        test_dest_zero_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
